bcd_to_bin_seq: RTL and testbench
=================================

// Module: bcd_to_bin_seq
// PURPOSE
//  Sequential 2-digit BCD-to-binary converter: the inverse of the binary-max-to-BCD counting path.
//  Takes tens/ones BCD digits (same digit_2/digit_1 pairing the BCD counter drives).
//  Returns the binary value via reverse double-dabble: one shift/correct step per clock.
//  Sits after the counter or keypad entry so BCD values can be compared or used in binary.
// PARAMETERS
//  BIN_W    7    width of bin_out; legal values are >= 7; result is zero-extended above bit 6
//  ITER     7    shift iterations; fixed at 7 (enough for 0..99); do not override
// PORTS
//  CLK      in   1      clock; all logic on rising edge
//  RST      in   1      synchronous, active-high reset
//  start    in   1      request a conversion; sampled only in IDLE
//  digit_2  in   4      tens BCD digit; captured on the accepted start cycle
//  digit_1  in   4      ones BCD digit; captured on the accepted start cycle
//  busy     out  1      high from the cycle after an accepted start through the DONE cycle
//  done     out  1      one-cycle pulse; bin_out/err are valid and updated this cycle
//  err      out  1      set with done when a captured digit is > 9; held until the next done
//  bin_out  out  BIN_W  converted value; held until the next done
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, err=0, bin_out=0, shift register=0.
//  Reset mid-conversion aborts at once. No done pulse. The partial result is discarded.
//  State machine (states IDLE, SHIFT, DONE):
//   IDLE:  start=1 -> capture digits into sr[14:0] = {digit_2, digit_1, 7'b0}; cnt=0.
//          If digit_2>9 or digit_1>9 -> next state DONE with err_pending=1.
//          Otherwise -> next state SHIFT.
//          start=0 -> stay in IDLE.
//   SHIFT: each cycle: t = sr>>1. Then for each nibble t[14:11] and t[10:7]:
//          if nibble>=8, subtract 3 from it. sr <= t; cnt++.
//          After the 7th SHIFT cycle (cnt==6) -> DONE.
//   DONE:  done=1; busy=1; bin_out <= err_pending ? 0 : {zeros, sr[6:0]}; err <= err_pending.
//          Next state is always IDLE.
//  Latency:
//   Valid digits: start accepted at edge T; done and the new bin_out appear 8 cycles later (T+8).
//   Invalid digit: done, err=1 and bin_out=0 appear at T+1 (no shifting).
//  start while busy (SHIFT or DONE) is ignored and not queued.
//  digit_1/digit_2 changes after the capture edge do not affect the result in flight.
//  start in IDLE on the cycle right after DONE is accepted: back-to-back conversions every 9 cycles.
//  Holding start high continuously produces a conversion every 9 cycles.
//  err and bin_out change only on a done cycle. A valid conversion clears a previous err.
//  Arithmetic: every per-nibble correction stays in 4 bits (8..15 maps to 5..12); no carries between nibbles.
//  After 7 steps the BCD part of sr is 0 for any valid input; max result is 99 = 7'h63.
// TESTING
//  1. RST=1 for 3 cycles -> busy=0, done=0, err=0, bin_out=0.
//  2. digit_2=7, digit_1=3, start pulse -> done exactly 8 cycles later; bin_out=73 (0x49); err=0.
//  3. Convert 99, 00, 09, 90 in turn -> bin_out = 99, 0, 9, 90; each done 8 cycles after its start.
//  4. digit_2=4'hA, digit_1=2, start -> done 1 cycle later; err=1, bin_out=0.
//     Then convert 15 -> bin_out=15, err=0.
//  5. Start 73; change digits to 15 and pulse start during SHIFT -> one done only; bin_out=73.
//  6. Start 42; assert RST on the 4th SHIFT cycle -> no done pulse; outputs return to reset values.
//     Next start of 42 -> bin_out=42.

Source files
------------

// File: rtl/bcd_to_bin_seq.sv
// Sequential two-digit BCD to binary converter using reverse double-dabble.
// It performs one shift/correct step per clock and pulses done when the result is ready.
module bcd_to_bin_seq #(
    parameter int BIN_W = 7,
    parameter int ITER  = 7
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [3:0]       digit_2,
    input  logic [3:0]       digit_1,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [BIN_W-1:0] bin_out
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [14:0]      sr_q, sr_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [BIN_W-1:0] bin_q, bin_d;

    logic [14:0]      shifted;
    logic [14:0]      t;
    logic             bad_digit;

    // One reverse double-dabble step: shift right, then take 3 from any BCD nibble >= 8.
    always_comb begin
        t       = sr_q >> 1;
        shifted = t;
        if (t[14:11] >= 4'd8) begin
            shifted[14:11] = t[14:11] - 4'd3;
        end
        if (t[10:7] >= 4'd8) begin
            shifted[10:7] = t[10:7] - 4'd3;
        end
    end

    assign bad_digit = (digit_2 > 4'd9) || (digit_1 > 4'd9);

    // The result and the error flag are loaded on entry to DONE, so they are valid while done is high.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        bin_d   = bin_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d  = {digit_2, digit_1, 7'b0};
                    cnt_d = 3'd0;
                    if (bad_digit) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        bin_d   = '0;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                sr_d  = shifted;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'(ITER - 1)) begin
                    state_d = DONE;
                    err_d   = 1'b0;
                    bin_d   = BIN_W'(shifted[6:0]);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            bin_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            bin_q   <= bin_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign err     = err_q;
    assign bin_out = bin_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Scoreboard bench for bcd_to_bin_seq: stimulus pushes hand-computed expectations,
// and a negedge monitor pops and checks one expectation on every done pulse.
module tb_bcd_to_bin_seq;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       start = 1'b0;
    logic [3:0] digit_2 = 4'd0;
    logic [3:0] digit_1 = 4'd0;
    logic       busy;
    logic       done;
    logic       err;
    logic [6:0] bin_out;

    typedef struct {
        int bin;
        int err;
        int lat;
        int accept_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_exp;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    bcd_to_bin_seq #(.BIN_W(7), .ITER(7)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .start  (start),
        .digit_2(digit_2),
        .digit_1(digit_1),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .bin_out(bin_out)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Latency counts the edge that accepts start up to the edge that samples done.
    always @(negedge CLK) begin
        if (!RST && done) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 1, 0);
            end else begin
                mon_exp = sb.pop_front();
                checkOutput("bin_out", int'(bin_out), mon_exp.bin);
                checkOutput("err", int'(err), mon_exp.err);
                checkOutput("latency", cyc + 1 - mon_exp.accept_cyc, mon_exp.lat);
                checkOutput("busy_with_done", int'(busy), 1);
            end
        end
    end

    // Called at a negedge; waits for IDLE, then drives a one-cycle start pulse.
    task automatic applyStimulus(input logic [3:0] d2, input logic [3:0] d1,
                                 input int exp_bin, input int exp_err, input int exp_lat);
        exp_t e;
        int   waited;
        waited = 0;
        while ((busy || done) && waited < 50) begin
            @(negedge CLK);
            waited++;
        end
        if (busy || done) checkOutput("idle_timeout", 1, 0);
        digit_2      = d2;
        digit_1      = d1;
        start        = 1'b1;
        e.bin        = exp_bin;
        e.err        = exp_err;
        e.lat        = exp_lat;
        e.accept_cyc = cyc + 1;
        sb.push_back(e);
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic waitDrain();
        int waited;
        waited = 0;
        while (sb.size() != 0 && waited < 40) begin
            @(negedge CLK);
            waited++;
        end
        if (sb.size() != 0) begin
            checkOutput("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge CLK);
    endtask

    initial begin
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_err", int'(err), 0);
        checkOutput("reset_bin", int'(bin_out), 0);
        RST = 1'b0;
        @(negedge CLK);

        applyStimulus(4'd7, 4'd3, 73, 0, 8);
        waitDrain();

        applyStimulus(4'd9, 4'd9, 99, 0, 8);
        waitDrain();
        applyStimulus(4'd0, 4'd0, 0, 0, 8);
        waitDrain();
        applyStimulus(4'd0, 4'd9, 9, 0, 8);
        waitDrain();
        applyStimulus(4'd9, 4'd0, 90, 0, 8);
        waitDrain();

        applyStimulus(4'hA, 4'd2, 0, 1, 1);
        waitDrain();
        applyStimulus(4'd1, 4'd5, 15, 0, 8);
        waitDrain();

        // A start during SHIFT with new digits must neither queue nor disturb the conversion.
        applyStimulus(4'd7, 4'd3, 73, 0, 8);
        @(negedge CLK);
        digit_2 = 4'd1;
        digit_1 = 4'd5;
        start   = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        waitDrain();
        repeat (12) @(negedge CLK);
        checkOutput("no_extra_conversion", int'(busy), 0);

        applyStimulus(4'd4, 4'd2, 42, 0, 8);
        repeat (3) @(negedge CLK);
        checkOutput("busy_in_shift", int'(busy), 1);
        RST = 1'b1;
        sb.delete();
        @(negedge CLK);
        RST = 1'b0;
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_done", int'(done), 0);
        checkOutput("abort_err", int'(err), 0);
        checkOutput("abort_bin", int'(bin_out), 0);
        repeat (12) @(negedge CLK);
        checkOutput("abort_stays_idle", int'(busy), 0);

        applyStimulus(4'd4, 4'd2, 42, 0, 8);
        waitDrain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got running, expected finished");
        $fatal(1, "[TB] global timeout");
    end

endmodule
